cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling controller between the cache arrays and the multicycle main memory (memory4c, 4-cycle read latency, 16-bit words). On a cache miss it stalls the pipeline and issues 8 sequential word reads to fill one 16-byte block. It steers returning words into the data array and pulses the tag/metadata write on the final word. It is the downstream fill engine that the cache top instantiates and drives with miss_detected / miss_address.

Parameters:
ADDR_WIDTH, 16, byte address width
WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2); offset bits = log2(WORDS_PER_BLOCK)+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  level, cache lookup missed this cycle
miss_address  input  ADDR_WIDTH  byte address of the missing access
memory_data_valid  input  1  memory4c read data valid this cycle
memory_data  input  16  memory4c read data
fsm_busy  output  1  stall request to pipeline/cache
mem_en  output  1  memory read enable (one request per cycle)
mem_wr  output  1  memory write enable, tied 0 by this block
memory_address  output  ADDR_WIDTH  read request address
write_data_array  output  1  data-array write strobe
data_word_sel  output  3  word index within block for the data-array write (log2(WORDS_PER_BLOCK))
data_array_in  output  16  word to write into data array
write_tag_array  output  1  one-cycle tag/valid update strobe
fill_block_addr  output  ADDR_WIDTH  latched block-aligned address (offset bits zero)

Behaviour:
- States: IDLE, FILL. Registers: state, base (block address), issue_cnt (0..8), recv_cnt (0..7).
- Reset (rst_n low, asynchronous): state=IDLE, counters=0, base=0. All outputs 0 during and after reset until a miss.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected), combinational, so the stall starts in the same cycle the miss is seen.
- IDLE: on a rising edge with miss_detected=1, base <= miss_address with offset bits cleared; issue_cnt <= 0; recv_cnt <= 0; next state FILL.
- FILL issue: mem_en=1 while issue_cnt<8. memory_address = base | (issue_cnt<<1). issue_cnt increments each cycle and saturates at 8.
- FILL receive: write_data_array = memory_data_valid. data_word_sel = recv_cnt. data_array_in = memory_data (pass-through, same cycle). recv_cnt increments on each valid.
- Completion: on the cycle memory_data_valid=1 and recv_cnt==7, write_tag_array=1 (same cycle as the last data write) and next state is IDLE.
- Timing with memory4c: FILL cycles 0-7 issue, cycles 4-11 return data. Total of 12 FILL cycles plus the IDLE detect cycle. fsm_busy drops on the cycle after write_tag_array.
- fill_block_addr = base, held stable through FILL and after it, until the next miss.
- miss_detected during FILL is ignored (no restart, no re-latch).
- memory_data_valid in IDLE is ignored: no writes, no counter change.
- miss_address offset bits never affect memory_address.
- Address arithmetic: the OR never carries; base is aligned. A block at 16'hFFF0 issues FFF0..FFFE with no wrap.
- Reset asserted mid-FILL: immediate return to IDLE, all strobes 0. A partial block is never tag-written (valid stays clear).
- A miss asserted in the same cycle as the final write_tag_array is not accepted, because the FSM is still in FILL. The cache re-asserts it the next cycle, which the FSM then accepts from IDLE.

Optional Feature:
CACHE_FILL_PERF_EN
- Defined: adds output miss_count[15:0]. It increments on each IDLE->FILL transition, wraps FFFF->0000, and resets to 0.
- Also adds output fill_active_cycles[15:0]. It increments on every cycle in FILL and saturates at FFFF.
- Not defined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, toggle clk, then release -> fsm_busy, mem_en, write_data_array, write_tag_array all 0; fill_block_addr=0000.
- Miss at 16'h1237 with memory4c model -> memory_address 1230,1232,...,123E on FILL cycles 0-7; 8 data writes with data_word_sel 0..7 on cycles 4-11; write_tag_array once with the last write; fill_block_addr=1230; busy drops on cycle 12.
- Miss held high for the whole fill at 16'h00A0, then pulsed again at 16'h4000 during FILL -> exactly one fill of 00A0, no re-latch; 4000 accepted only after return to IDLE.
- Spurious memory_data_valid=1 with data BEEF in IDLE -> no write_data_array, recv_cnt unchanged on the next fill (first write has data_word_sel=0).
- rst_n pulsed low at FILL cycle 6 -> outputs 0 immediately, no write_tag_array; a new miss at 16'h2000 fills cleanly from word 0.
- Boundary at 16'hFFF4 -> memory_address FFF0..FFFE, no wrap to 0000. With CACHE_FILL_PERF_EN, after 3 fills -> miss_count=3, fill_active_cycles=36.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss-handling fill engine between the cache arrays and a multicycle
//   main memory (4-cycle read latency, 16-bit words). A miss stalls the
//   pipeline and starts a block fill. The engine issues one word read per
//   cycle for the whole block. Each returning word is steered into the data
//   array. The tag/valid write is pulsed together with the final word.
//
//   Optional feature macro: CACHE_FILL_PERF_EN
//     Adds the miss_count and fill_active_cycles performance counters.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   miss_detected       level, cache lookup missed this cycle
//   miss_address        byte address of the missing access
//   memory_data_valid   memory read data valid this cycle
//   memory_data         memory read data
//   fsm_busy            stall request to pipeline/cache
//   mem_en              memory read enable (one request per cycle)
//   mem_wr              memory write enable, always 0
//   memory_address      read request address
//   write_data_array    data-array write strobe
//   data_word_sel       word index within the block for the data-array write
//   data_array_in       word written into the data array
//   write_tag_array     one-cycle tag/valid update strobe
//   fill_block_addr     latched block-aligned address of the current/last fill
//   miss_count          (CACHE_FILL_PERF_EN) IDLE->FILL transitions, wrapping
//   fill_active_cycles  (CACHE_FILL_PERF_EN) cycles spent in FILL, saturating
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               fsm_busy,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_WIDTH-1:0]              memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_sel,
    output logic [15:0]                        data_array_in,
    output logic                               write_tag_array,
`ifdef CACHE_FILL_PERF_EN
    output logic [15:0]                        miss_count,
    output logic [15:0]                        fill_active_cycles,
`endif
    output logic [ADDR_WIDTH-1:0]              fill_block_addr
);

    localparam int SEL_W = $clog2(WORDS_PER_BLOCK);
    // Byte offset covers the word index plus the byte-in-word bit.
    localparam int OFF_W = SEL_W + 1;
    localparam int CNT_W = SEL_W + 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]      ISSUE_DONE = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [SEL_W-1:0]      LAST_WORD  = SEL_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]      issue_cnt;
    logic [SEL_W-1:0]      recv_cnt;

    logic                  in_fill;
    logic                  start_fill;
    logic                  last_beat;
    logic                  issuing;
    logic [ADDR_WIDTH-1:0] word_off;

    assign in_fill    = (state == FILL);
    assign start_fill = (state == IDLE) && miss_detected;
    assign last_beat  = in_fill && memory_data_valid && (recv_cnt == LAST_WORD);
    // issue_cnt saturates at ISSUE_DONE, which doubles as the "all requested" flag.
    assign issuing    = in_fill && (issue_cnt < ISSUE_DONE);

    always_comb begin
        state_nxt        = state;
        word_off         = '0;
        fsm_busy         = in_fill || start_fill;
        mem_en           = issuing;
        mem_wr           = 1'b0;
        memory_address   = '0;
        write_data_array = in_fill && memory_data_valid;
        data_word_sel    = recv_cnt;
        data_array_in    = '0;
        write_tag_array  = last_beat;
        fill_block_addr  = base;

        if (start_fill) begin
            state_nxt = FILL;
        end
        if (last_beat) begin
            state_nxt = IDLE;
        end

        // base is block aligned, so OR-ing the word offset never carries.
        word_off[SEL_W:1] = issue_cnt[SEL_W-1:0];
        if (issuing) begin
            memory_address = base | word_off;
        end
        if (write_data_array) begin
            data_array_in = memory_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (start_fill) begin
                base      <= miss_address & ~OFF_MASK;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else if (in_fill) begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (memory_data_valid) begin
                    recv_cnt <= recv_cnt + 1'b1;
                end
            end
        end
    end

`ifdef CACHE_FILL_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count         <= '0;
            fill_active_cycles <= '0;
        end else begin
            if (start_fill) begin
                miss_count <= miss_count + 16'd1;
            end
            if (in_fill) begin
                fill_active_cycles <= sat_inc16(fill_active_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_word_sel;
    logic [15:0] data_array_in;
    logic        write_tag_array;
    logic [15:0] fill_block_addr;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0] miss_count;
    logic [15:0] fill_active_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int fills = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .mem_wr            (mem_wr),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_word_sel     (data_word_sel),
        .data_array_in     (data_array_in),
        .write_tag_array   (write_tag_array),
`ifdef CACHE_FILL_PERF_EN
        .miss_count        (miss_count),
        .fill_active_cycles(fill_active_cycles),
`endif
        .fill_block_addr   (fill_block_addr)
    );

    // Memory model: 4-cycle read latency, data = address ^ 5A5A.
    logic [3:0]  pv;
    logic [15:0] pa [4];
    logic        force_valid;
    logic [15:0] force_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else        pv <= {pv[2:0], mem_en};
    end
    always @(posedge clk) begin
        pa[0] <= memory_address;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign memory_data_valid = pv[3] | force_valid;
    assign memory_data       = force_valid ? force_data : (pa[3] ^ 16'h5A5A);

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic e_busy, input logic e_en,
                              input logic [15:0] e_addr, input logic e_wda,
                              input logic [2:0] e_sel, input logic [15:0] e_data,
                              input logic e_tag, input logic [15:0] e_fba, input bit chk_fba);
        chk({nm, ".busy"}, 32'(fsm_busy), 32'(e_busy));
        chk({nm, ".mem_en"}, 32'(mem_en), 32'(e_en));
        if (e_en) chk({nm, ".addr"}, 32'(memory_address), 32'(e_addr));
        chk({nm, ".wda"}, 32'(write_data_array), 32'(e_wda));
        if (e_wda) begin
            chk({nm, ".sel"}, 32'(data_word_sel), 32'(e_sel));
            chk({nm, ".data"}, 32'(data_array_in), 32'(e_data));
        end
        chk({nm, ".tag"}, 32'(write_tag_array), 32'(e_tag));
        chk({nm, ".mem_wr"}, 32'(mem_wr), 32'd0);
        if (chk_fba) chk({nm, ".fba"}, 32'(fill_block_addr), 32'(e_fba));
    endtask

    // Detect cycle plus 12 FILL cycles. Optionally pulses a foreign miss at
    // FILL cycles 5-6 and/or raises the next miss on the final (tag) cycle.
    task automatic run_fill(input logic [15:0] a, input logic [15:0] eb, input bit hold,
                            input bit pulse, input bit chain, input logic [15:0] chain_a);
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = a;
        @(negedge clk);
        expect_out("detect", 1'b1, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            miss_detected = hold;
            miss_address  = a;
            if (pulse && (c == 5 || c == 6)) begin
                miss_detected = 1'b1;
                miss_address  = 16'h4000;
            end
            if (chain && c == 11) begin
                miss_detected = 1'b1;
                miss_address  = chain_a;
            end
            @(negedge clk);
            expect_out($sformatf("fill%0h.c%0d", eb, c), 1'b1, (c < 8), eb + 16'(2 * c),
                       (c >= 4), 3'(c - 4), (eb + 16'(2 * (c - 4))) ^ 16'h5A5A,
                       (c == 11), eb, 1'b1);
        end
        fills++;
    endtask

    task automatic end_idle(input logic [15:0] eb);
        @(posedge clk); #1;
        miss_detected = 1'b0;
        @(negedge clk);
        expect_out("after", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, eb, 1'b1);
    endtask

    typedef struct {
        logic [15:0] addr;
        bit          hold;
        bit          pulse;
        bit          chain;
        logic [15:0] chain_addr;
        logic [15:0] exp_base;
    } fill_vec_t;

    fill_vec_t vecs [4];

    initial begin
        vecs[0] = '{16'h1237, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1230};
        vecs[1] = '{16'h00A0, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h00A0};
        vecs[2] = '{16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000};
        vecs[3] = '{16'hFFF4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFF0};

        rst_n         = 1'b0;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        force_valid   = 1'b0;
        force_data    = 16'h0;

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_out("in_reset", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("post_reset", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0000, 1'b1);

        // Table of fills.
        for (int i = 0; i < 4; i++) begin
            run_fill(vecs[i].addr, vecs[i].exp_base, vecs[i].hold, vecs[i].pulse,
                     vecs[i].chain, vecs[i].chain_addr);
            if (!vecs[i].chain) end_idle(vecs[i].exp_base);
        end

        // Spurious valid in IDLE is ignored.
        @(posedge clk); #1;
        force_valid = 1'b1;
        force_data  = 16'hBEEF;
        @(negedge clk);
        expect_out("spurious", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'hFFF0, 1'b1);
        @(posedge clk); #1;
        force_valid = 1'b0;
        run_fill(16'h3456, 16'h3450, 1'b0, 1'b0, 1'b0, 16'h0);
        end_idle(16'h3450);

        // Reset asserted at FILL cycle 6.
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = 16'h5558;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            miss_detected = 1'b0;
            @(negedge clk);
            chk($sformatf("midrst.tag.c%0d", c), 32'(write_tag_array), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        expect_out("midrst", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst.hold.tag", 32'(write_tag_array), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fills = 0;

        run_fill(16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h0);
        end_idle(16'h2000);
        run_fill(16'hFFFA, 16'hFFF0, 1'b0, 1'b0, 1'b0, 16'h0);
        end_idle(16'hFFF0);
        run_fill(16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
        end_idle(16'h0000);

`ifdef CACHE_FILL_PERF_EN
        chk("perf.miss_count", 32'(miss_count), 32'(fills));
        chk("perf.fill_active_cycles", 32'(fill_active_cycles), 32'(12 * fills));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
